sort_frame_serializer: RTL

//  Output stage of the pipelined sorting network. Captures one N-lane sorted vector

---
 rtl/sort_frame_serializer.sv | 58 +++++
 1 files changed

// File: rtl/sort_frame_serializer.sv
// sort_frame_serializer: buffers sorted frames in a ping-pong pair and streams them out one element per beat
module sort_frame_serializer #(
    parameter int WIDTH = 32,
    parameter int N     = 8,
    parameter int DESC  = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_last,
    output logic               busy,
    output logic               overflow,
    input  logic               clr_ovf
);
    localparam int IW = (N > 2) ? $clog2(N) : 1;
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
    state_t             state;
    logic [N*WIDTH-1:0] frame_buf [2];
    logic               wsel, rsel;
    logic [IW-1:0]      idx, lane;
    logic               xfer, done, space, cap, drop;
    assign out_valid = state != EMPTY;
    assign busy      = out_valid;
    assign lane      = (DESC != 0) ? IW'(N - 1) - idx : idx;
    assign out_data  = frame_buf[rsel][int'(lane)*WIDTH +: WIDTH];
    assign out_last  = out_valid && idx == IW'(N - 1);
    assign xfer      = out_valid && out_ready;
    assign done      = xfer && out_last;
    assign space     = state != FULL || done;
    assign cap       = in_valid && space;
    assign drop      = in_valid && !space;
    // occupancy FSM, slot pointers, element pointer and sticky overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= EMPTY;
            frame_buf[0] <= '0;
            frame_buf[1] <= '0;
            wsel         <= 1'b0;
            rsel         <= 1'b0;
            idx          <= '0;
            overflow     <= 1'b0;
        end else begin
            if (cap) begin
                frame_buf[wsel] <= in_data;
                wsel            <= ~wsel;
            end
            if (xfer) idx <= out_last ? '0 : idx + 1'b1;
            if (done) rsel <= ~rsel;
            if (cap && !done) state <= (state == EMPTY) ? ONE : FULL;
            else if (done && !cap) state <= (state == FULL) ? ONE : EMPTY;
            overflow <= drop || (overflow && !clr_ovf);
        end
    end
endmodule
